imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It accepts a byte stream, assembles the bytes into 32-bit instruction words, and drives the instruction-memory write port with word-aligned addresses starting at 0. It holds the CPU off the instruction memory until the image is fully loaded and its checksum has been verified. It sits between the host byte link (UART/debug receiver) and the write side of the instruction memory, which the CPU reads with `ce`/`addr[11:2]`.

---
 rtl/imem_loader_if.sv | 41 ++++
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the host byte link and the instruction-memory write port used by
// imem_loader.
//   start       - one-cycle load request (host -> loader)
//   byte_valid  - byte_data valid this cycle (host -> loader)
//   byte_data   - stream byte (host -> loader)
//   byte_ready  - loader accepts a byte this cycle (loader -> host)
//   we          - instruction-memory write strobe, one cycle per word
//   waddr       - word-aligned byte address of the word being written
//   wdata       - instruction word being written
//   busy        - load in progress
//   done        - last load finished with matching checksum (level)
//   err         - last load failed (level)
//   cpu_hold    - CPU must stall and keep the instruction ROM disabled
// -----------------------------------------------------------------------------
interface imem_loader_if;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    // Host / stimulus side.
    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata, busy, done, err, cpu_hold
    );

    // Loader side.
    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, we, waddr, wdata, busy, done, err, cpu_hold
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time instruction-memory writer. Receives LEN_HI, LEN_LO (big-endian
// word count N), N*4 data bytes (each word MSB first) and a checksum byte
// (8-bit sum of the data bytes). Each assembled word is written to waddr =
// index*4 starting at 0. The CPU is held off until the image has loaded and
// its checksum has matched.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - imem_loader_if.slave (byte link, write port, status)
// Parameter:
//   DEPTH - instruction-memory depth in words; largest legal word count
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    // One extra bit so the index can represent N = DEPTH.
    localparam int IDX_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR
    } state_e;

    // Status flags as a function of the state they will take effect in:
    // {byte_ready, busy, done, err, cpu_hold}.
    function automatic logic [4:0] flags_of(state_e s);
        case (s)
            LEN_HI, LEN_LO, DATA, CHK: flags_of = 5'b11001;
            DONE:                      flags_of = 5'b00100;
            ERR:                       flags_of = 5'b00011;
            default:                   flags_of = 5'b00001;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [4:0]         flags_q;
    logic [15:0]        len_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         cnt_q;
    logic [23:0]        asm_q;    // first three bytes of the current word
    logic [7:0]         sum_q;
    logic               we_q;
    logic [31:0]        waddr_q;
    logic [31:0]        wdata_q;

    logic               accept;
    logic [15:0]        len_in;
    logic               last_word;

    assign accept    = bus.byte_valid && flags_q[4];
    assign len_in    = {len_q[15:8], bus.byte_data};
    assign last_word = (16'(idx_q) + 16'd1) == len_q;

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (bus.start) state_d = LEN_HI;
            LEN_HI:          if (accept) state_d = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (len_in > 16'(DEPTH))  state_d = ERR;
                    else if (len_in == 16'd0) state_d = CHK;
                    else                      state_d = DATA;
                end
            end
            DATA:            if (accept && cnt_q == 2'd3 && last_word) state_d = CHK;
            CHK:             if (accept) state_d = (bus.byte_data == sum_q) ? DONE : ERR;
            default:         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            flags_q <= flags_of(IDLE);
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            // Flags registered from the next state so they line up with it.
            flags_q <= flags_of(state_d);
            we_q    <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        idx_q <= '0;
                        cnt_q <= '0;
                        sum_q <= '0;
                    end
                end
                LEN_HI: if (accept) len_q[15:8] <= bus.byte_data;
                LEN_LO: if (accept) len_q[7:0]  <= bus.byte_data;
                DATA: begin
                    if (accept) begin
                        asm_q <= {asm_q[15:0], bus.byte_data};
                        sum_q <= sum_q + bus.byte_data;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            wdata_q <= {asm_q, bus.byte_data};
                            waddr_q <= 32'({idx_q, 2'b00});
                            we_q    <= 1'b1;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = flags_q[4];
    assign bus.busy       = flags_q[3];
    assign bus.done       = flags_q[2];
    assign bus.err        = flags_q[1];
    assign bus.cpu_hold   = flags_q[0];
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader: nominal load, byte gaps, bad checksum,
// oversize and empty images, mid-load reset and a full-depth image.
// -----------------------------------------------------------------------------
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if bus ();
    imem_loader #(.DEPTH(1024)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Write log captured mid-cycle.
    logic [31:0] log_addr [2048];
    logic [31:0] log_data [2048];
    int          we_cnt   = 0;
    int          double_we = 0;
    logic        prev_we  = 1'b0;

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            log_addr[we_cnt % 2048] = bus.waddr;
            log_data[we_cnt % 2048] = bus.wdata;
            we_cnt = we_cnt + 1;
            if (prev_we) double_we = double_we + 1;
        end
        prev_we = (bus.we === 1'b1);
    end

    logic [7:0] stream_a [14];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one byte starting at a negedge; it transfers on the following posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        check("byte_ready", 32'(bus.byte_ready), 32'd1);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_ready", 32'(bus.byte_ready), 32'd1);
        check("start_busy",  32'(bus.busy),       32'd1);
    endtask

    task automatic send_stream(input logic [7:0] chk, input int maxgap);
        for (int i = 0; i < 14; i++)
            send_byte(stream_a[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        send_byte(chk, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        idle_bus();
    endtask

    task automatic check_three(input int base);
        check("we_count", 32'(we_cnt - base), 32'd3);
        check("w0_addr", log_addr[base],     32'h0);
        check("w0_data", log_data[base],     32'h34011100);
        check("w1_addr", log_addr[base + 1], 32'h4);
        check("w1_data", log_data[base + 1], 32'h34020020);
        check("w2_addr", log_addr[base + 2], 32'h8);
        check("w2_data", log_data[base + 2], 32'h3403FF00);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h);
        check({tag, "_done"},  32'(bus.done),       32'(d));
        check({tag, "_err"},   32'(bus.err),        32'(e));
        check({tag, "_hold"},  32'(bus.cpu_hold),   32'(h));
        check({tag, "_busy"},  32'(bus.busy),       32'd0);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_we"},    32'(bus.we),         32'd0);
        check({tag, "_waddr"}, bus.waddr,           32'd0);
        check({tag, "_wdata"}, bus.wdata,           32'd0);
        check({tag, "_busy"},  32'(bus.busy),       32'd0);
        check({tag, "_done"},  32'(bus.done),       32'd0);
        check({tag, "_err"},   32'(bus.err),        32'd0);
        check({tag, "_hold"},  32'(bus.cpu_hold),   32'd1);
    endtask

    function automatic logic [31:0] full_word(input int i);
        logic [9:0] k;
        k = 10'(i);
        return {k[7:0], ~k[7:0], 8'hA5, 6'b0, k[9:8]};
    endfunction

    initial begin
        int base;
        int bad;
        logic [7:0]  sum;
        logic [31:0] w;

        stream_a = '{8'h00, 8'h03,
                     8'h34, 8'h01, 8'h11, 8'h00,
                     8'h34, 8'h02, 8'h00, 8'h20,
                     8'h34, 8'h03, 8'hFF, 8'h00};
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Nominal load, one byte per cycle.
        base = we_cnt;
        pulse_start();
        send_stream(8'hD2, 0);
        check_status("nominal", 1'b1, 1'b0, 1'b0);
        check_three(base);

        // Same image with random valid gaps.
        base = we_cnt;
        pulse_start();
        send_stream(8'hD2, 5);
        check_status("gaps", 1'b1, 1'b0, 1'b0);
        check_three(base);

        // Bad checksum: words are still written, then error.
        base = we_cnt;
        pulse_start();
        send_stream(8'hD3, 0);
        check_status("badchk", 1'b0, 1'b1, 1'b1);
        check_three(base);

        // Recovery after error.
        base = we_cnt;
        pulse_start();
        send_stream(8'hD2, 0);
        check_status("recover", 1'b1, 1'b0, 1'b0);
        check_three(base);

        // Oversize image: N = 1025.
        base = we_cnt;
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        idle_bus();
        check_status("oversize", 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("oversize_we", 32'(we_cnt - base), 32'd0);

        // Empty image: N = 0, checksum 00.
        base = we_cnt;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        idle_bus();
        check_status("empty", 1'b1, 1'b0, 1'b0);
        check("empty_we", 32'(we_cnt - base), 32'd0);

        // Reset after six data bytes.
        base = we_cnt;
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(stream_a[i], 0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_we", 32'(we_cnt - base), 32'd1);
        check("midrst_state_idle", 32'(bus.byte_ready), 32'd0);
        base = we_cnt;
        pulse_start();
        send_stream(8'hD2, 0);
        check_status("postrst", 1'b1, 1'b0, 1'b0);
        check_three(base);

        // Full-depth image, start pulsed mid-load.
        base = we_cnt;
        sum  = 8'h00;
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 1024; i++) begin
            w = full_word(i);
            for (int b = 3; b >= 0; b--) begin
                send_byte(w[b*8 +: 8], 0);
                sum = sum + w[b*8 +: 8];
            end
            if (i == 500) bus.start = 1'b1;
            if (i == 501) bus.start = 1'b0;
        end
        send_byte(sum, 0);
        idle_bus();
        check_status("full", 1'b1, 1'b0, 1'b0);
        check("full_we", 32'(we_cnt - base), 32'd1024);
        check("full_last_addr", log_addr[(we_cnt - 1) % 2048], 32'hFFC);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (log_addr[(base + i) % 2048] !== 32'(i * 4)) bad++;
            if (log_data[(base + i) % 2048] !== full_word(i)) bad++;
        end
        check("full_contents", 32'(bad), 32'd0);

        check("no_double_we", 32'(double_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
